dmem_bank: RTL and testbench

Parametrised, synthesizable data-memory slave for the core's `d_mem_*` port. It replaces the fixed 16-bit, zero-wait behavioural data bank used around the core with a configurable-width, configurable-depth byte-lane RAM. It adds programmable wait states, a registered ready handshake, out-of-range error reporting and a selectable power-up fill pattern. It sits directly on the core's data bus in simulation and FPGA builds.

---
 rtl/dmem_if.sv | 24 ++
 rtl/dmem_bank.sv | 126 ++++++++++++
 tb/tb_dmem_bank.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Data-memory bus between the core (master) and a data bank (slave).
interface dmem_if #(
    parameter int LANES  = 2,
    parameter int ADDR_W = 16
);
    logic                 d_mem_assert;
    logic                 d_mem_cmd;
    logic [ADDR_W-1:0]    d_mem_addr;
    logic [LANES-1:0]     d_mem_be;
    logic [8*LANES-1:0]   d_mem_data_out;
    logic [8*LANES-1:0]   d_mem_data_in;
    logic                 d_mem_rdy;
    logic                 d_mem_err;

    modport master (
        output d_mem_assert, d_mem_cmd, d_mem_addr, d_mem_be, d_mem_data_out,
        input  d_mem_data_in, d_mem_rdy, d_mem_err
    );

    modport slave (
        input  d_mem_assert, d_mem_cmd, d_mem_addr, d_mem_be, d_mem_data_out,
        output d_mem_data_in, d_mem_rdy, d_mem_err
    );
endinterface

// File: rtl/dmem_bank.sv
// Byte-lane data memory slave with programmable wait states, registered
// ready pulse, out-of-range error and selectable power-up fill.
module dmem_bank #(
    parameter int LANES       = 2,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0,
    parameter int INIT_MODE   = 0
) (
    input  logic   clk,
    input  logic   a_rst,
    dmem_if.slave  bus
);
    localparam int LG       = $clog2(LANES);
    localparam int IDX_W    = ADDR_W - LG;
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit INIT_PAT = (INIT_MODE == 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 cmd_q, cmd_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [LANES-1:0]     be_q, be_d;
    logic [8*LANES-1:0]   wdata_q, wdata_d;
    logic                 rdy_q, rdy_d;
    logic                 err_q, err_d;
    logic                 access;
    logic                 in_range;

    assign in_range = (32'(idx_q) < 32'(DEPTH));

    // Next-state logic: capture in IDLE, count down in WAIT, perform the
    // access on the edge that enters RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdy_d   = 1'b0;
        err_d   = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.d_mem_assert) begin
                    cmd_d   = bus.d_mem_cmd;
                    idx_d   = IDX_W'(bus.d_mem_addr >> LG);
                    be_d    = bus.d_mem_be;
                    wdata_d = bus.d_mem_data_out;
                    cnt_d   = 8'(WAIT_CYCLES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = RESP;
                    access  = 1'b1;
                    rdy_d   = 1'b1;
                    err_d   = ~in_range;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control and request registers; reset discards any pending request.
    always_ff @(posedge clk) begin
        if (!a_rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            cmd_q   <= 1'b0;
            idx_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
        end
    end

    assign bus.d_mem_rdy = rdy_q;
    assign bus.d_mem_err = err_q;

    // One RAM per byte lane. Contents are stored XORed with the power-up
    // pattern so a zero-filled array reads back as the pattern without
    // needing a computed initial image.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [7:0] mem [DEPTH] = '{default: 8'h00};
        logic [7:0] pat;
        logic [7:0] rd_q;

        assign pat = INIT_PAT ? 8'(((32'(idx_q) << LG) | 32'(gi)) >> 8) : 8'h00;

        // Lane write: committed only when the access completes in range.
        always_ff @(posedge clk) begin
            if (a_rst && access && cmd_q && be_q[gi] && in_range) begin
                mem[idx_q[AW-1:0]] <= wdata_q[8*gi +: 8] ^ pat;
            end
        end

        // Registered lane read; holds its value across writes.
        always_ff @(posedge clk) begin
            if (!a_rst) begin
                rd_q <= 8'h00;
            end else if (access && !cmd_q) begin
                rd_q <= (be_q[gi] && in_range) ? (mem[idx_q[AW-1:0]] ^ pat) : 8'h00;
            end
        end

        assign bus.d_mem_data_in[8*gi +: 8] = rd_q;
    end
endmodule

// File: tb/tb_dmem_bank.sv
// Self-checking bench: five dmem_bank configurations against a byte-addressed
// reference model.
module tb_dmem_bank;
    localparam int NI = 5;
    // Instance index:                      4        3       2      1       0
    localparam logic [NI-1:0][31:0] P_WAIT  = {32'd4,    32'd0,     32'd0,  32'd3,    32'd0};
    localparam logic [NI-1:0][31:0] P_DEPTH = {32'd1024, 32'd32768, 32'd64, 32'd1024, 32'd1024};
    localparam logic [NI-1:0][31:0] P_INIT  = {32'd0,    32'd1,     32'd0,  32'd0,    32'd0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]        rst_n, req_v, req_cmd, rdy, err;
    logic [NI-1:0][15:0]  req_addr, req_wd, rdata;
    logic [NI-1:0][1:0]   req_be;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        dmem_if #(.LANES(2), .ADDR_W(16)) bus ();
        assign bus.d_mem_assert   = req_v[gi];
        assign bus.d_mem_cmd      = req_cmd[gi];
        assign bus.d_mem_addr     = req_addr[gi];
        assign bus.d_mem_be       = req_be[gi];
        assign bus.d_mem_data_out = req_wd[gi];
        assign rdata[gi]          = bus.d_mem_data_in;
        assign rdy[gi]            = bus.d_mem_rdy;
        assign err[gi]            = bus.d_mem_err;
        dmem_bank #(
            .LANES(2), .ADDR_W(16), .DEPTH(int'(P_DEPTH[gi])),
            .WAIT_CYCLES(int'(P_WAIT[gi])), .INIT_MODE(int'(P_INIT[gi]))
        ) u_dut (.clk(clk), .a_rst(rst_n[gi]), .bus(bus));
    end

    int checks = 0;
    int failures = 0;
    logic [7:0]  mem_m [NI][65536];
    logic [15:0] last_rd [NI];

    // Reference model: plain byte-addressed memory plus range rule.
    function automatic bit model_err(input int i, input logic [15:0] a);
        return (32'(a >> 1) >= P_DEPTH[i]);
    endfunction

    function automatic logic [15:0] model_read(input int i, input logic [15:0] a, input logic [1:0] b);
        logic [15:0] r = 16'h0;
        int base = int'(a) & 32'hFFFE;
        if (model_err(i, a)) return 16'h0;
        for (int l = 0; l < 2; l++) if (b[l]) r[8*l +: 8] = mem_m[i][base + l];
        return r;
    endfunction

    task automatic model_write(input int i, input logic [15:0] a, input logic [1:0] b, input logic [15:0] wd);
        int base = int'(a) & 32'hFFFE;
        if (model_err(i, a)) return;
        for (int l = 0; l < 2; l++) if (b[l]) mem_m[i][base + l] = wd[8*l +: 8];
    endtask

    // Drive one request, wait for rdy (bounded), report what came back.
    task automatic access(input int i, input bit c, input logic [15:0] a, input logic [1:0] b,
                          input logic [15:0] wd, input bit hold, input bit mutate,
                          output logic [15:0] rd, output logic er, output int lat, output logic rdy2);
        @(negedge clk);
        req_v[i] = 1'b1; req_cmd[i] = c; req_addr[i] = a; req_be[i] = b; req_wd[i] = wd;
        lat = -1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k == 0 && mutate) begin
                req_cmd[i] = ~c; req_addr[i] = a ^ 16'h0002; req_be[i] = ~b; req_wd[i] = ~wd;
            end
            if (rdy[i]) begin lat = k + 1; break; end
        end
        rd = rdata[i]; er = err[i];
        if (!hold) req_v[i] = 1'b0;
        @(negedge clk);
        rdy2 = rdy[i];
        req_v[i] = 1'b0;
        $display("txn inst=%0d cmd=%0d addr=%h be=%b wd=%h rd=%h err=%0d lat=%0d", i, c, a, b, wd, rd, er, lat);
    endtask

    task automatic test_reset();
        for (int i = 0; i < NI; i++) begin
            checks++; if (rdy[i] !== 1'b0) begin failures++; $display("FAIL reset_rdy inst=%0d got=%b exp=0", i, rdy[i]); end
            checks++; if (err[i] !== 1'b0) begin failures++; $display("FAIL reset_err inst=%0d got=%b exp=0", i, err[i]); end
            checks++; if (rdata[i] !== 16'h0) begin failures++; $display("FAIL reset_data inst=%0d got=%h exp=0000", i, rdata[i]); end
        end
    endtask

    // Generic random access on an instance with full checking.
    task automatic rand_op(input int i, input bit c, input logic [15:0] a, input logic [1:0] b, input logic [15:0] wd);
        logic [15:0] rd, exp_rd; logic er, r2; int lat;
        exp_rd = c ? last_rd[i] : model_read(i, a, b);
        access(i, c, a, b, wd, 1'b0, 1'b0, rd, er, lat, r2);
        checks++; if (lat !== int'(P_WAIT[i]) + 2) begin failures++; $display("FAIL latency inst=%0d got=%0d exp=%0d", i, lat, int'(P_WAIT[i]) + 2); end
        checks++; if (er !== model_err(i, a)) begin failures++; $display("FAIL err inst=%0d addr=%h got=%b exp=%b", i, a, er, model_err(i, a)); end
        checks++; if (rd !== exp_rd) begin failures++; $display("FAIL data inst=%0d cmd=%0d addr=%h be=%b got=%h exp=%h", i, c, a, b, rd, exp_rd); end
        checks++; if (r2 !== 1'b0) begin failures++; $display("FAIL rdy_width inst=%0d got=%b exp=0", i, r2); end
        if (c) model_write(i, a, b, wd); else last_rd[i] = exp_rd;
    endtask

    task automatic test_basic();
        rand_op(0, 1'b1, 16'h00A0, 2'b11, 16'hBEEF);
        rand_op(0, 1'b0, 16'h00A0, 2'b11, 16'h0000);
        checks++; if (last_rd[0] !== 16'hBEEF) begin failures++; $display("FAIL basic_model got=%h exp=beef", last_rd[0]); end
    endtask

    task automatic test_byte_lanes();
        rand_op(0, 1'b1, 16'h00A0, 2'b01, 16'h12AB);
        rand_op(0, 1'b0, 16'h00A0, 2'b11, 16'h0000);
        rand_op(0, 1'b0, 16'h00A1, 2'b10, 16'h0000);
        rand_op(0, 1'b0, 16'h00A0, 2'b00, 16'h0000);
        rand_op(0, 1'b1, 16'h00A0, 2'b00, 16'h7777);
        rand_op(0, 1'b0, 16'h00A0, 2'b11, 16'h0000);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [15:0] a;
            if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(16'h0800, 16'hFFFF));
            else a = 16'($urandom_range(0, 16'h07FF));
            rand_op(0, 1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), 16'($urandom));
        end
    endtask

    task automatic test_wait();
        logic [15:0] rd; logic er, r2; int lat, pulses;
        rand_op(1, 1'b1, 16'h0020, 2'b11, 16'hA5C3);
        rand_op(1, 1'b1, 16'h0022, 2'b11, 16'h0F0F);
        // Hold assert through RESP and change inputs after capture.
        access(1, 1'b0, 16'h0020, 2'b01, 16'h1234, 1'b1, 1'b1, rd, er, lat, r2);
        checks++; if (lat !== 5) begin failures++; $display("FAIL wait_latency got=%0d exp=5", lat); end
        checks++; if (rd !== model_read(1, 16'h0020, 2'b01)) begin failures++; $display("FAIL wait_data got=%h exp=%h", rd, model_read(1, 16'h0020, 2'b01)); end
        checks++; if (r2 !== 1'b0) begin failures++; $display("FAIL wait_rdy_width got=%b exp=0", r2); end
        last_rd[1] = model_read(1, 16'h0020, 2'b01);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin @(negedge clk); if (rdy[1]) pulses++; end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL wait_extra_capture got=%0d exp=0", pulses); end
        rand_op(1, 1'b0, 16'h0022, 2'b11, 16'h0000);
    endtask

    task automatic test_back_to_back();
        int pulses, p1, p2;
        pulses = 0; p1 = -1; p2 = -1;
        @(negedge clk);
        req_v[1] = 1'b1; req_cmd[1] = 1'b1; req_addr[1] = 16'h0040; req_be[1] = 2'b11; req_wd[1] = 16'h6C6C;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rdy[1]) begin pulses++; if (p1 < 0) p1 = k; else p2 = k; end
            if (k == 11) req_v[1] = 1'b0;
        end
        $display("txn inst=1 back_to_back pulses=%0d first=%0d second=%0d", pulses, p1, p2);
        model_write(1, 16'h0040, 2'b11, 16'h6C6C);
        checks++; if (pulses !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", pulses); end
        checks++; if (p1 !== 5) begin failures++; $display("FAIL b2b_first got=%0d exp=5", p1); end
        checks++; if (p2 !== 11) begin failures++; $display("FAIL b2b_second got=%0d exp=11", p2); end
        rand_op(1, 1'b0, 16'h0040, 2'b11, 16'h0000);
    endtask

    task automatic test_out_of_range();
        rand_op(2, 1'b1, 16'h0000, 2'b11, 16'h3C5A);
        rand_op(2, 1'b1, 16'h0080, 2'b11, 16'hFFFF);
        rand_op(2, 1'b0, 16'h0000, 2'b11, 16'h0000);
        rand_op(2, 1'b0, 16'h0080, 2'b11, 16'h0000);
        rand_op(2, 1'b1, 16'h007E, 2'b11, 16'h9119);
        rand_op(2, 1'b0, 16'h007E, 2'b11, 16'h0000);
        rand_op(2, 1'b0, 16'hFFFE, 2'b11, 16'h0000);
    endtask

    task automatic test_init_fill();
        rand_op(3, 1'b0, 16'hC000, 2'b11, 16'h0000);
        checks++; if (last_rd[3] !== 16'hC0C0) begin failures++; $display("FAIL init_model got=%h exp=c0c0", last_rd[3]); end
        rand_op(3, 1'b0, 16'hB0FE, 2'b01, 16'h0000);
        for (int n = 0; n < 10; n++)
            rand_op(3, 1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)), 16'($urandom));
        rand_op(3, 1'b1, 16'h7F00, 2'b10, 16'hD200);
        rand_op(3, 1'b0, 16'h7F00, 2'b11, 16'h0000);
    endtask

    task automatic test_reset_mid();
        int pulses;
        rand_op(4, 1'b1, 16'h0010, 2'b11, 16'h4E21);
        rand_op(4, 1'b0, 16'h0010, 2'b11, 16'h0000);
        @(negedge clk);
        req_v[4] = 1'b1; req_cmd[4] = 1'b1; req_addr[4] = 16'h0010; req_be[4] = 2'b11; req_wd[4] = 16'h5555;
        pulses = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (rdy[4]) pulses++;
            if (k == 1) req_v[4] = 1'b0;
            if (k == 2) rst_n[4] = 1'b0;
            if (k == 4) rst_n[4] = 1'b1;
        end
        $display("txn inst=4 reset_mid pulses=%0d", pulses);
        last_rd[4] = 16'h0;
        checks++; if (pulses !== 0) begin failures++; $display("FAIL reset_mid_rdy got=%0d exp=0", pulses); end
        checks++; if (rdata[4] !== 16'h0) begin failures++; $display("FAIL reset_mid_data got=%h exp=0000", rdata[4]); end
        checks++; if (err[4] !== 1'b0) begin failures++; $display("FAIL reset_mid_err got=%b exp=0", err[4]); end
        rand_op(4, 1'b0, 16'h0010, 2'b11, 16'h0000);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            last_rd[i] = 16'h0;
            for (int b = 0; b < 65536; b++) mem_m[i][b] = (P_INIT[i] == 32'd1) ? 8'(b >> 8) : 8'h00;
        end
        rst_n = '0; req_v = '0; req_cmd = '0; req_addr = '0; req_be = '0; req_wd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = '1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_byte_lanes();
        test_random();
        test_wait();
        test_back_to_back();
        test_out_of_range();
        test_init_fill();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
